mem_ram_burst_master: RTL and testbench
=======================================

Name: mem_ram_burst_master

Overview:
- Initiator for the 64x8 synchronous RAM request interface: read_rq, write_rq, rw_address, write_data, read_data.
- Accepts one burst command at a time: a write or read of 1..64 consecutive words.
- Write bursts take words from a valid/ready input stream; read bursts return words on a valid/ready output stream.
- Sits between a client (DMA, test sequencer) and the RAM.

Parameters:
- ADDR_W, 6, RAM address width; depth is 2**ADDR_W.
- DATA_W, 8, RAM word width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  master idle, command accepted when cmd_valid&&cmd_ready
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  ADDR_W  start address
- cmd_len  input  ADDR_W  burst length minus one (0 = 1 word, 63 = 64 words)
- wr_valid  input  1  write-stream word offered
- wr_ready  output  1  write-stream word consumed this cycle
- wr_data  input  DATA_W  write-stream word
- rd_valid  output  1  read-stream word held
- rd_ready  input  1  read-stream sink accepts
- rd_data  output  DATA_W  read-stream word
- done  output  1  one-cycle pulse, burst complete
- err  output  1  one-cycle pulse, command rejected (feature only; constant 0 otherwise)
- read_rq  output  1  RAM read request
- write_rq  output  1  RAM write request
- rw_address  output  ADDR_W  RAM address
- write_data  output  DATA_W  RAM write word
- read_data  input  DATA_W  RAM read word, combinational from RAM while read_rq=1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - cmd_ready=1; rd_valid=0, rd_data=0.
  - done=0, err=0.
  - read_rq=0, write_rq=0, rw_address=0, write_data=0.
- Reset mid-burst aborts the burst immediately; no further RAM requests are issued and no done pulse is produced.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr=cmd_addr and cnt=cmd_len.
  - Go to WRITE if cmd_write=1, else READ.
  - cmd_ready=0 in every other state; commands offered while busy wait.
- WRITE:
  - wr_ready = wr_valid. write_rq = wr_valid, rw_address = addr, write_data = wr_data, all combinational.
  - The RAM commits the word on the same rising edge.
  - On each consumed word: addr <= addr+1 (mod 2**ADDR_W, wraps 63->0), cnt <= cnt-1.
  - On the word where cnt==0: done=1 next cycle, go to IDLE.
  - wr_valid=0 stalls the burst with write_rq=0. Data words arriving in IDLE are not consumed (wr_ready=0).
- READ:
  - Issue condition is slot_free = !rd_valid || rd_ready.
  - When slot_free: read_rq=1, rw_address=addr. read_data is sampled into rd_data at the clock edge and rd_valid <= 1.
  - When not slot_free: read_rq=0 and the address is held.
  - Advance addr/cnt on every issue, with the same wrap as WRITE.
  - After issuing the cnt==0 word, go to DRAIN.
- DRAIN: wait until rd_valid && rd_ready, then done=1 next cycle, go to IDLE.
- RAM-request invariants:
  - read_rq and write_rq are never both 1.
  - Both are 0 in IDLE and DRAIN.
- Throughput:
  - One word per cycle with no stalls.
  - An N-word write occupies N cycles after accept.
  - A read burst with rd_ready held 1 gives its first rd_valid one cycle after the first issue.
- rd_data stays stable while rd_valid=1 and rd_ready=0.
- done asserts one cycle after the final write edge or the final read handshake.

Optional Feature:
- Macro: MEM_RAM_BURST_BOUND_CHECK_EN.
- With the macro defined:
  - A command with cmd_addr+cmd_len > 2**ADDR_W-1 is still accepted (cmd_ready=1).
  - It performs no RAM access, returns to IDLE, and pulses err=1 for one cycle the next cycle. No done pulse.
- Without the macro: addresses wrap modulo 2**ADDR_W and err is tied 0.

Test Plan:
- Write burst: addr=5, len=3, wr_data 0xA1,0xA2,0xA3,0xA4 back-to-back.
  - write_rq high 4 cycles at addresses 5..8, then done.
  - A read burst addr=5, len=3 returns 0xA1..0xA4 in order.
- Wrap (feature off): write addr=62, len=3 with 0x11..0x14.
  - Writes land at 62, 63, 0, 1.
  - Read back of the same range matches.
- Backpressure: read burst of 4 words with rd_ready low 3 cycles after the first word.
  - rd_data is held stable; read_rq=0 during the stall.
  - No word is lost or duplicated; done follows the 4th handshake.
- Write stall: wr_valid toggles 1,0,1,0.
  - write_rq mirrors wr_valid; the address advances only on consumed words.
  - Busy behaviour: cmd_valid asserted mid-burst sees cmd_ready=0 until IDLE.
- Reset mid-burst: rst low on the 2nd word of an 8-word write.
  - All outputs at reset values immediately; only 1 word written.
  - The next command is accepted normally.
- Feature on: cmd addr=60, len=7.
  - err pulses once; no read_rq/write_rq asserted; RAM contents unchanged.

Source files
------------

// File: rtl/mem_ram_burst_master.sv
// Burst initiator for a synchronous single-port RAM: one write or read burst of 1..2**ADDR_W words.
// Define MEM_RAM_BURST_BOUND_CHECK_EN to reject bursts that would run past the top address.
module mem_ram_burst_master #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              read_rq,
  output logic              write_rq,
  output logic [ADDR_W-1:0] rw_address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic              err_q;

  logic slot_free;
  logic consume;
  logic issue;
  logic bound_bad;

  // A read may issue whenever the output slot is empty or is being emptied this cycle.
  assign slot_free = !rd_valid_q || rd_ready;
  assign consume   = (state_q == StWrite) && wr_valid;
  assign issue     = (state_q == StRead) && slot_free;

`ifdef MEM_RAM_BURST_BOUND_CHECK_EN
  logic [ADDR_W:0] end_addr;
  assign end_addr  = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign bound_bad = end_addr[ADDR_W];
`else
  assign bound_bad = 1'b0;
`endif

  assign cmd_ready  = (state_q == StIdle);
  assign wr_ready   = consume;
  assign write_rq   = consume;
  assign read_rq    = issue;
  assign rw_address = (state_q == StWrite || state_q == StRead) ? addr_q : '0;
  assign write_data = (state_q == StWrite) ? wr_data : '0;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (bound_bad) begin
              err_q <= 1'b1;
            end else begin
              addr_q  <= cmd_addr;
              cnt_q   <= cmd_len;
              state_q <= cmd_write ? StWrite : StRead;
            end
          end
        end
        StWrite: begin
          if (wr_valid) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - ADDR_W'(1);
            if (cnt_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StRead: begin
          if (slot_free) begin
            rd_data_q  <= read_data;
            rd_valid_q <= 1'b1;
            addr_q     <= addr_q + ADDR_W'(1);
            cnt_q      <= cnt_q - ADDR_W'(1);
            if (cnt_q == '0) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (rd_valid_q && rd_ready) begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ram_burst_master.sv
// Randomised bench for mem_ram_burst_master: a RAM model plus an expected-contents array
// drive write/read bursts and check protocol, addressing, data and timing.
module tb_mem_ram_burst_master;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err;
  logic          read_rq;
  logic          write_rq;
  logic [AW-1:0] rw_address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] wdata   [DEPTH];
  logic          ram_load;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_ram_burst_master #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .done       (done),
    .err        (err),
    .read_rq    (read_rq),
    .write_rq   (write_rq),
    .rw_address (rw_address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read while requested.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= exp_mem[i];
    end else if (write_rq) begin
      ram[rw_address] <= write_data;
    end
  end
  assign read_data = read_rq ? ram[rw_address] : '0;

  function automatic int ram_diffs();
    int d = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) d++;
    return d;
  endfunction

  // mode 0: back-to-back, 1: wr_valid toggles 1,0,1,0.., 2: random gaps
  task automatic run_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode,
                           input bit busy_cmd, input string tag);
    int            idx;
    int            cyc;
    int            d;
    logic [AW-1:0] ea;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    wr_valid  = 1'b1; wr_data = 8'h5A;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || write_rq !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: cmd_ready=%b wr_ready=%b write_rq=%b, want 1 0 0",
               tag, cmd_ready, wr_ready, write_rq);
    end
    @(negedge clk);
    cmd_valid = busy_cmd; cmd_write = 1'b0;
    idx = 0; cyc = 0; ea = a;
    while (idx <= int'(l) && cyc < 400) begin
      wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
      wr_data  = wdata[idx];
      #1;
      n_cmp++;
      if (write_rq !== wr_valid || wr_ready !== wr_valid || cmd_ready !== 1'b0 ||
          read_rq !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rw_address !== ea ||
          write_data !== wdata[idx]) begin
        n_fail++;
        $display("FAIL %s word%0d: wrq=%b wrdy=%b crdy=%b rrq=%b done=%b addr=%0d data=%h, want %b %b 0 0 0 %0d %h",
                 tag, idx, write_rq, wr_ready, cmd_ready, read_rq, done, rw_address, write_data,
                 wr_valid, wr_valid, ea, wdata[idx]);
      end
      if (wr_valid) begin
        exp_mem[ea] = wdata[idx];
        ea++;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'hC3;
    #1;
    n_cmp++;
    if (idx <= int'(l) || done !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b1 ||
        wr_ready !== 1'b0 || write_rq !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: words=%0d done=%b err=%b crdy=%b wrdy=%b wrq=%b, want %0d 1 0 1 0 0",
               tag, idx, done, err, cmd_ready, wr_ready, write_rq, int'(l) + 1);
    end
    if (mode == 0) begin
      n_cmp++;
      if (cyc != int'(l) + 1) begin
        n_fail++;
        $display("FAIL %s cycles: got %0d want %0d", tag, cyc, int'(l) + 1);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    d = ram_diffs();
    n_cmp++;
    if (done !== 1'b0 || write_rq !== 1'b0 || d != 0) begin
      n_fail++;
      $display("FAIL %s post: done=%b wrq=%b ram_diffs=%0d, want 0 0 0", tag, done, write_rq, d);
    end
  endtask

  // mode 0: rd_ready held 1, 1: rd_ready low 3 cycles after first word, 2: random
  task automatic run_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode,
                          input string tag);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held;
    logic [AW-1:0] ea;
    logic          want_rq;
    bit            held_valid;
    int            got;
    int            cyc;
    int            stall;
    int            iss;
    for (int i = 0; i <= int'(l); i++) exp_q.push_back(exp_mem[AW'(int'(a) + i)]);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l; rd_ready = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || read_rq !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: crdy=%b rrq=%b rvld=%b, want 1 0 0", tag, cmd_ready, read_rq, rd_valid);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 0; cyc = 0; stall = 0; iss = 0; ea = a; held_valid = 0; held = '0;
    while (got <= int'(l) && cyc < 400) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (stall == 0) : ($urandom_range(0, 2) != 0);
      #1;
      want_rq = (iss <= int'(l)) && (!rd_valid || rd_ready);
      n_cmp++;
      if (write_rq !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0 || read_rq !== want_rq ||
          (read_rq && rw_address !== ea) || (rd_valid && rd_data !== exp_q[got]) ||
          (held_valid && (rd_valid !== 1'b1 || rd_data !== held))) begin
        n_fail++;
        $display("FAIL %s cyc%0d: wrq=%b crdy=%b done=%b rrq=%b addr=%0d rvld=%b rdata=%h, want 0 0 0 %b %0d - %h",
                 tag, cyc, write_rq, cmd_ready, done, read_rq, rw_address, rd_valid, rd_data,
                 want_rq, ea, exp_q[got]);
      end
      if (read_rq) begin
        iss++;
        ea++;
      end
      held_valid = rd_valid && !rd_ready;
      held       = rd_data;
      if (!rd_ready && stall > 0) stall--;
      if (rd_valid && rd_ready) begin
        got++;
        if (mode == 1 && got == 1) stall = 3;
      end
      cyc++;
      @(negedge clk);
    end
    rd_ready = 1'b1;
    #1;
    n_cmp++;
    if (got <= int'(l) || done !== 1'b1 || err !== 1'b0 || rd_valid !== 1'b0 ||
        cmd_ready !== 1'b1 || read_rq !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: words=%0d done=%b err=%b rvld=%b crdy=%b rrq=%b, want %0d 1 0 0 1 0",
               tag, got, done, err, rd_valid, cmd_ready, read_rq, int'(l) + 1);
    end
    if (mode == 0) begin
      n_cmp++;
      if (cyc != int'(l) + 2) begin
        n_fail++;
        $display("FAIL %s cycles: got %0d want %0d", tag, cyc, int'(l) + 2);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post: done=%b want 0", tag, done);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'($urandom);
    rst = 1'b0; ram_load = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b1; wr_data = 8'hFF; rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ram_load = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0 || done !== 1'b0 ||
        err !== 1'b0 || read_rq !== 1'b0 || write_rq !== 1'b0 || rw_address !== '0 ||
        write_data !== '0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: crdy=%b rvld=%b rdata=%h done=%b err=%b rrq=%b wrq=%b addr=%0d wdata=%h wrdy=%b",
               cmd_ready, rd_valid, rd_data, done, err, read_rq, write_rq, rw_address,
               write_data, wr_ready);
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) wdata[i] = DW'(8'hA1 + i);
    run_write(6'd5, 6'd3, 0, 1'b0, "wr_basic");
    n_cmp++;
    if (ram[5] !== 8'hA1 || ram[6] !== 8'hA2 || ram[7] !== 8'hA3 || ram[8] !== 8'hA4) begin
      n_fail++;
      $display("FAIL wr_basic ram: %h %h %h %h, want a1 a2 a3 a4", ram[5], ram[6], ram[7], ram[8]);
    end
    run_read(6'd5, 6'd3, 0, "rd_basic");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wdata[i] = DW'(8'h11 + i);
    run_write(6'd62, 6'd3, 0, 1'b0, "wr_wrap");
    n_cmp++;
    if (ram[62] !== 8'h11 || ram[63] !== 8'h12 || ram[0] !== 8'h13 || ram[1] !== 8'h14) begin
      n_fail++;
      $display("FAIL wr_wrap ram: %h %h %h %h, want 11 12 13 14", ram[62], ram[63], ram[0], ram[1]);
    end
    run_read(6'd62, 6'd3, 0, "rd_wrap");
  endtask

  task automatic test_backpressure();
    run_read(AW'($urandom_range(0, 60)), 6'd3, 1, "rd_backpressure");
  endtask

  task automatic test_write_stall();
    for (int i = 0; i < 4; i++) wdata[i] = DW'($urandom);
    run_write(6'd10, 6'd3, 1, 1'b1, "wr_stall");
  endtask

  task automatic test_reset_mid_burst();
    int d;
    for (int i = 0; i < 8; i++) wdata[i] = DW'($urandom);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd20; cmd_len = 6'd7;
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = wdata[0];
    @(negedge clk);
    exp_mem[20] = wdata[0];
    wr_data = wdata[1];
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || write_rq !== 1'b0 || read_rq !== 1'b0 ||
        rw_address !== '0 || write_data !== '0 || rd_valid !== 1'b0 || rd_data !== '0 ||
        done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: crdy=%b wrdy=%b wrq=%b rrq=%b addr=%0d wdata=%h rvld=%b done=%b err=%b",
               cmd_ready, wr_ready, write_rq, read_rq, rw_address, write_data, rd_valid, done, err);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    rst = 1'b1;
    #1;
    d = ram_diffs();
    n_cmp++;
    if (done !== 1'b0 || d != 0) begin
      n_fail++;
      $display("FAIL rst_mid ram: done=%b ram_diffs=%0d, want 0 0", done, d);
    end
    run_read(6'd20, 6'd1, 0, "rd_after_rst");
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [AW-1:0] l;
    for (int t = 0; t < 14; t++) begin
      a = AW'($urandom_range(0, 63));
      l = AW'($urandom_range(0, 15));
`ifdef MEM_RAM_BURST_BOUND_CHECK_EN
      if (int'(a) + int'(l) > 63) a = AW'(63 - int'(l));
`endif
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(l); i++) wdata[i] = DW'($urandom);
        run_write(a, l, 2, 1'b1, "wr_random");
      end else begin
        run_read(a, l, 2, "rd_random");
      end
    end
  endtask

`ifdef MEM_RAM_BURST_BOUND_CHECK_EN
  task automatic test_bound_check();
    int errs;
    int rqs;
    int d;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd60; cmd_len = 6'd7;
    wr_valid = 1'b1; wr_data = 8'h77;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bound accept: crdy=%b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    errs = 0; rqs = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (err === 1'b1) errs++;
      if (read_rq !== 1'b0 || write_rq !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) rqs++;
      if (c == 0) begin
        n_cmp++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL bound err_timing: err=%b want 1", err);
        end
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    d = ram_diffs();
    n_cmp++;
    if (errs != 1 || rqs != 0 || d != 0) begin
      n_fail++;
      $display("FAIL bound: err_pulses=%0d bad_cycles=%0d ram_diffs=%0d, want 1 0 0", errs, rqs, d);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; ram_load = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    test_reset();
    test_write_read();
`ifndef MEM_RAM_BURST_BOUND_CHECK_EN
    test_wrap();
`endif
    test_backpressure();
    test_write_stall();
    test_reset_mid_burst();
`ifdef MEM_RAM_BURST_BOUND_CHECK_EN
    test_bound_check();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
